// File: rtl/jane_seq_pkg.sv
// Shared types and default sizes for the timestamp sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jane_seq_pkg;

    localparam int DEFAULT_WIDTH     = 128;
    localparam int DEFAULT_OUT_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/timestamp_sequencer.sv
// Applies timed output patterns: fetch (time,data,last), wait for count >= time, then register data to dout.
// Latency: dout updates on the edge that ends the first WAIT cycle with count >= held time.
// Backpressure: instr_ready is high only in FETCH, so one instruction is held at a time.
// Optional macro TIMESTAMP_SEQUENCER_LATE_FLAG_EN compiles in the sticky late flag; otherwise late is tied 0.
module timestamp_sequencer
    import jane_seq_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     count,
    output logic                 counter_reset,
    output logic                 counter_enable,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [WIDTH-1:0]     instr_time,
    input  logic [OUT_WIDTH-1:0] instr_data,
    input  logic                 instr_last,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 busy,
    output logic                 done,
    output logic                 late
);

    state_t                 state;
    state_t                 state_nxt;
    logic [WIDTH-1:0]       hold_time;
    logic [OUT_WIDTH-1:0]   hold_data;
    logic                   hold_last;
    logic                   due;
    logic                   fire;
    logic                   accept;
    logic                   restart;

    // Full-width unsigned compare; abort suppresses a fire in the same cycle.
    assign due     = (count >= hold_time);
    assign fire    = (state == ST_WAIT) && due && !abort;
    assign accept  = (state == ST_FETCH) && instr_valid && !abort;
    assign restart = ((state == ST_IDLE) || (state == ST_DONE)) && start && !abort;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides everything, start is only honoured in IDLE/DONE.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_nxt = ST_FETCH;
                ST_FETCH: if (instr_valid) state_nxt = ST_WAIT;
                ST_WAIT:  if (due) state_nxt = hold_last ? ST_DONE : ST_FETCH;
                ST_DONE:  if (start) state_nxt = ST_FETCH;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Moore outputs; DONE leaves the counter frozen but not cleared so its value stays readable.
    always_comb begin
        counter_reset  = 1'b0;
        counter_enable = 1'b0;
        instr_ready    = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state)
            ST_IDLE:  counter_reset = 1'b1;
            ST_FETCH: begin
                counter_enable = 1'b1;
                instr_ready    = 1'b1;
                busy           = 1'b1;
            end
            ST_WAIT:  begin
                counter_enable = 1'b1;
                busy           = 1'b1;
            end
            ST_DONE:  done = 1'b1;
            default:  counter_reset = 1'b1;
        endcase
    end

    // Holding registers: capture on transfer, cleared by abort so no stale instruction survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_time <= '0;
            hold_data <= '0;
            hold_last <= 1'b0;
        end else if (abort) begin
            hold_time <= '0;
            hold_data <= '0;
            hold_last <= 1'b0;
        end else if (accept) begin
            hold_time <= instr_time;
            hold_data <= instr_data;
            hold_last <= instr_last;
        end
    end

    // Output pattern register; only a fire changes it (abort leaves it untouched).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= '0;
        end else if (fire) begin
            dout <= hold_data;
        end
    end

`ifdef TIMESTAMP_SEQUENCER_LATE_FLAG_EN
    // Sticky late flag: set when an event fires strictly after its timestamp, cleared by a new run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            late <= 1'b0;
        end else if (restart) begin
            late <= 1'b0;
        end else if (fire && (count > hold_time)) begin
            late <= 1'b1;
        end
    end
`else
    logic unused_restart;
    assign unused_restart = restart;
    assign late = 1'b0;
`endif

endmodule
